// File: rtl/dff_chk_pkg.sv
// Shared types and helpers for the single-bit dff response checker.
package dff_chk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    HALT  = 3'd4
  } chk_state_t;

  localparam int CHK_CNT_W_DEF = 16;

  // Counters up to 32 bits wide; callers zero-extend in and truncate out.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/exp_pipe.sv
// Expectation delay line: LATENCY-deep shift register with a valid bit per stage.
module exp_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic shift,
  input  logic din,
  output logic dout,
  output logic full
);

  logic [LATENCY-1:0] data_q;
  logic [LATENCY-1:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= '0;
    end else if (flush) begin
      data_q <= '0;
      vld_q  <= '0;
    end else if (shift) begin
      data_q[0] <= din;
      vld_q[0]  <= 1'b1;
      for (int i = 1; i < LATENCY; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign dout = data_q[LATENCY-1];
  assign full = vld_q[LATENCY-1];

endmodule

// File: rtl/dff_checker.sv
// Response checker for the dff path: predicts q as d delayed by LATENCY edges,
// counts compares and mismatches, and flags pass/fail once the run completes.
module dff_checker
  import dff_chk_pkg::*;
#(
  parameter int LATENCY     = 1,
  parameter int NUM_CHECKS  = 40,
  parameter int CNT_W       = CHK_CNT_W_DEF,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             d_in,
  input  logic             q_in,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] first_err,
  output chk_state_t       dbg_state
);

  localparam logic [CNT_W-1:0] ALL1  = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_CHECKS);
  localparam logic [3:0]       LAT_C = 4'(LATENCY);

  chk_state_t       state_q, state_d;
  logic [3:0]       fill_q, fill_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic [CNT_W-1:0] chk_inc;
  logic             shift, flush, exp_bit, pipe_full, mis;

  exp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .shift (shift),
    .din   (d_in),
    .dout  (exp_bit),
    .full  (pipe_full)
  );

  assign chk_inc = chk_q + ONE;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    err_d   = err_q;
    chk_d   = chk_q;
    first_d = first_q;
    shift   = 1'b0;
    flush   = 1'b0;
    mis     = 1'b0;
    if (clr) begin
      state_d = IDLE;
      fill_d  = 4'd0;
      err_d   = '0;
      chk_d   = '0;
      first_d = ALL1;
      flush   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            shift   = 1'b1;
            fill_d  = 4'd1;
            state_d = (LAT_C == 4'd1) ? CHECK : FILL;
          end
        end
        FILL: begin
          if (!en) begin
            flush   = 1'b1;
            fill_d  = 4'd0;
            state_d = IDLE;
          end else begin
            shift  = 1'b1;
            fill_d = fill_q + 4'd1;
            if (fill_q + 4'd1 == LAT_C) state_d = CHECK;
          end
        end
        CHECK: begin
          if (!en) begin
            flush   = 1'b1;
            fill_d  = 4'd0;
            state_d = IDLE;
          end else begin
            shift = 1'b1;
            if (pipe_full) begin
              mis   = (q_in != exp_bit);
              chk_d = chk_inc;
              if (mis) begin
                err_d = CNT_W'(sat_inc(32'(err_q), 32'(ALL1)));
                if (err_q == '0) first_d = chk_q;
              end
              // A halting mismatch takes precedence over reaching the compare target.
              if (mis && (STOP_ON_ERR != 0)) state_d = HALT;
              else if (chk_inc == NUM_C)     state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= 4'd0;
      err_q   <= '0;
      chk_q   <= '0;
      first_q <= ALL1;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      first_q <= first_d;
    end
  end

  assign done      = (state_q == DONE) || (state_q == HALT);
  assign pass      = done && (err_q == '0);
  assign fail      = (err_q != '0);
  assign err_cnt   = err_q;
  assign chk_cnt   = chk_q;
  assign first_err = first_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dff_checker.sv
// Bench for dff_checker: three checker configurations share one stimulus stream,
// each watching its own dff-like response source.
module tb_dff_checker;

  localparam int NUM = 40;
  localparam int LAT [3] = '{1, 1, 3};
  localparam int STP [3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic en = 1'b0;
  logic d = 1'b0;
  logic inj = 1'b0;
  logic ff1 = 1'b0;
  logic [2:0] ff3 = 3'b000;
  logic [1:0] q_sel [3];
  logic q_w [3];

  logic done_o [3];
  logic pass_o [3];
  logic fail_o [3];
  logic [15:0] err_o [3];
  logic [15:0] chk_o [3];
  logic [15:0] first_o [3];
  dff_chk_pkg::chk_state_t st_o [3];

  int n_chk = 0;
  int n_err = 0;
  bit check_on = 0;

  // behavioural model state
  int m_chk [3];
  int m_err [3];
  int m_first [3];
  int m_start [3];
  bit m_fin [3];
  bit m_act [3];
  bit d_log [1024];
  int t = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ff1 <= d;
    ff3 <= {ff3[1:0], d};
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      case (q_sel[k])
        2'd0:    q_w[k] = ff1;
        2'd1:    q_w[k] = ff3[2];
        2'd2:    q_w[k] = 1'b0;
        default: q_w[k] = ff1 ^ inj;
      endcase
    end
  end

  dff_checker #(.LATENCY(1), .NUM_CHECKS(NUM), .CNT_W(16), .STOP_ON_ERR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .d_in(d), .q_in(q_w[0]),
    .done(done_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .err_cnt(err_o[0]),
    .chk_cnt(chk_o[0]), .first_err(first_o[0]), .dbg_state(st_o[0]));

  dff_checker #(.LATENCY(1), .NUM_CHECKS(NUM), .CNT_W(16), .STOP_ON_ERR(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .d_in(d), .q_in(q_w[1]),
    .done(done_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .err_cnt(err_o[1]),
    .chk_cnt(chk_o[1]), .first_err(first_o[1]), .dbg_state(st_o[1]));

  dff_checker #(.LATENCY(3), .NUM_CHECKS(NUM), .CNT_W(16), .STOP_ON_ERR(0)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .d_in(d), .q_in(q_w[2]),
    .done(done_o[2]), .pass(pass_o[2]), .fail(fail_o[2]), .err_cnt(err_o[2]),
    .chk_cnt(chk_o[2]), .first_err(first_o[2]), .dbg_state(st_o[2]));

  task automatic check(input string nm, input int k, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[u%0d]: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_chk[k] = 0; m_err[k] = 0; m_first[k] = 'hFFFF;
      m_fin[k] = 0; m_act[k] = 0; m_start[k] = 0;
    end
  endtask

  // Model: within an enabled run, every edge at least LAT edges after the run
  // started compares q against the d seen LAT edges earlier.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (clr) begin
          m_chk[k] = 0; m_err[k] = 0; m_first[k] = 'hFFFF; m_fin[k] = 0; m_act[k] = 0;
        end else if (m_fin[k]) begin
        end else if (!en) begin
          m_act[k] = 0;
        end else begin
          if (!m_act[k]) begin
            m_act[k] = 1;
            m_start[k] = t;
          end
          if (t - m_start[k] >= LAT[k]) begin
            bit mis;
            mis = (q_w[k] != d_log[(t - LAT[k]) % 1024]);
            if (mis) begin
              if (m_err[k] == 0) m_first[k] = m_chk[k];
              if (m_err[k] < 'hFFFF) m_err[k]++;
            end
            m_chk[k]++;
            if (mis && STP[k] != 0) m_fin[k] = 1;
            else if (m_chk[k] == NUM) m_fin[k] = 1;
          end
        end
      end
    end
    d_log[t % 1024] = d;
    t++;
  end

  always @(negedge clk) begin
    if (check_on) begin
      for (int k = 0; k < 3; k++) begin
        check("done", k, done_o[k], m_fin[k]);
        check("pass", k, pass_o[k], m_fin[k] && m_err[k] == 0);
        check("fail", k, fail_o[k], m_err[k] != 0);
        check("err_cnt", k, err_o[k], m_err[k]);
        check("chk_cnt", k, chk_o[k], m_chk[k]);
        check("first_err", k, first_o[k], m_first[k]);
      end
    end
  end

  task automatic step(input bit en_v, input bit d_v, input bit clr_v);
    en = en_v;
    d = d_v;
    clr = clr_v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag, input int k);
    check({tag, "_done"}, k, done_o[k], 0);
    check({tag, "_pass"}, k, pass_o[k], 0);
    check({tag, "_fail"}, k, fail_o[k], 0);
    check({tag, "_err"}, k, err_o[k], 0);
    check({tag, "_chk"}, k, chk_o[k], 0);
    check({tag, "_first"}, k, first_o[k], 'hFFFF);
    check({tag, "_state"}, k, int'(st_o[k]), int'(dff_chk_pkg::IDLE));
  endtask

  function automatic bit pat(input int i);
    return bit'(((10 * i + 3) / 7) % 2);
  endfunction

  initial begin
    logic [31:0] rnd;
    rnd = 32'hB4E1_9C37;
    q_sel[0] = 2'd0; q_sel[1] = 2'd0; q_sel[2] = 2'd1;
    model_reset();
    #12;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) check_reset_vals("rst", k);
    check_on = 1;

    // good dff on every checker: all pass
    step(0, 0, 1);
    for (int i = 0; i < 45; i++) begin
      step(1, pat(i), 0);
      if (i == 39) check("s1_done_early", 0, done_o[0], 0);
      if (i == 40) begin
        check("s1_done", 0, done_o[0], 1);
        check("s1_pass", 0, pass_o[0], 1);
        check("s1_err", 0, err_o[0], 0);
        check("s1_chk", 0, chk_o[0], 40);
        check("s1_first", 0, first_o[0], 'hFFFF);
        check("s1_done_l3_early", 2, done_o[2], 0);
      end
      if (i == 42) check("s1_pass_l3", 2, pass_o[2], 1);
    end

    // q stuck at 0 with d held high
    q_sel[0] = 2'd2; q_sel[1] = 2'd2; q_sel[2] = 2'd2;
    step(0, 1, 1);
    for (int i = 0; i < 45; i++) begin
      step(1, 1, 0);
      if (i == 1) begin
        check("s2_halt_done", 1, done_o[1], 1);
        check("s2_halt_chk", 1, chk_o[1], 1);
        check("s2_halt_state", 1, int'(st_o[1]), int'(dff_chk_pkg::HALT));
      end
    end
    check("s2_err", 0, err_o[0], 40);
    check("s2_first", 0, first_o[0], 0);
    check("s2_fail", 0, fail_o[0], 1);
    check("s2_pass", 0, pass_o[0], 0);
    check("s2_err_l3", 2, err_o[2], 40);

    // single injected error at compare 5, halting checker
    q_sel[0] = 2'd0; q_sel[1] = 2'd3; q_sel[2] = 2'd1;
    step(0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      inj = (i == 6);
      step(1, pat(i), 0);
    end
    inj = 0;
    check("s3_done", 1, done_o[1], 1);
    check("s3_chk", 1, chk_o[1], 6);
    check("s3_err", 1, err_o[1], 1);
    check("s3_first", 1, first_o[1], 5);
    check("s3_state", 1, int'(st_o[1]), int'(dff_chk_pkg::HALT));

    // enable drop after 10 compares, then resume
    q_sel[1] = 2'd0;
    step(0, 0, 1);
    for (int i = 0; i < 11; i++) step(1, pat(i), 0);
    check("s4_chk10", 0, chk_o[0], 10);
    for (int i = 0; i < 3; i++) begin
      step(0, pat(i + 3), 0);
      check("s4_hold_chk", 0, chk_o[0], 10);
      check("s4_hold_state", 0, int'(st_o[0]), int'(dff_chk_pkg::IDLE));
    end
    step(1, 1, 0);
    check("s4_refill_chk", 0, chk_o[0], 10);
    for (int j = 1; j <= 30; j++) begin
      step(1, pat(j), 0);
      if (j == 1) check("s4_resume_chk", 0, chk_o[0], 11);
      if (j == 29) check("s4_done_early", 0, done_o[0], 0);
    end
    check("s4_done", 0, done_o[0], 1);
    check("s4_chk40", 0, chk_o[0], 40);
    check("s4_pass", 0, pass_o[0], 1);

    // 3-edge checker watching a 1-stage dff with an irregular d sequence
    q_sel[2] = 2'd0;
    step(0, 0, 1);
    for (int i = 0; i < 45; i++) step(1, rnd[i % 32], 0);
    check("s5_err_nonzero", 2, err_o[2] != 0, 1);
    check("s5_fail", 2, fail_o[2], 1);

    // async reset mid-check, then clr from DONE
    q_sel[0] = 2'd2; q_sel[1] = 2'd2; q_sel[2] = 2'd2;
    step(0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    check("s6_pre_state", 0, int'(st_o[0]), int'(dff_chk_pkg::CHECK));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("async", 0);
    check_reset_vals("async", 2);
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 42; i++) step(1, 1, 0);
    check("s6_done_before_clr", 0, done_o[0], 1);
    step(1, 1, 1);
    check_reset_vals("clr", 0);
    check_reset_vals("clr", 1);
    check_reset_vals("clr", 2);
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dff_checker.md
# dff_checker

Synthesizable response checker for the single-bit `dff` path. It observes the stimulus applied to a DUT (`d_in`) and the DUT output (`q_in`). It predicts `q_in` as `d_in` delayed by `LATENCY` clock edges and counts mismatches. It also records the check index of the first failure and raises `pass`/`fail` after `NUM_CHECKS` compared samples. It is the receiving end of the stimulus/response loop, so the `dff` path can be checked on hardware or in a bench without `$monitor` inspection.

## Interface
- `LATENCY`, 1: expected DUT delay in `clk` edges; legal range 1..8.
- `NUM_CHECKS`, 40: number of compared samples before `done`.
- `CNT_W`, 16: width of all counters; `NUM_CHECKS` must be at most 2^`CNT_W`-1.
- `STOP_ON_ERR`, 0: 1 = halt checking on the first mismatch.
- `clk` in 1: single clock; all sampling on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear of state, pipeline and counters; has priority over `en`.
- `en` in 1: check enable.
- `d_in` in 1: stimulus as applied to the DUT `d`.
- `q_in` in 1: DUT `q`.
- `done` out 1: `NUM_CHECKS` samples compared, or halted.
- `pass` out 1: `done` and `err_cnt`==0.
- `fail` out 1: sticky; set when `err_cnt` != 0.
- `err_cnt` out `CNT_W`: mismatch count; saturates at all-ones.
- `chk_cnt` out `CNT_W`: compared-sample count.
- `first_err` out `CNT_W`: `chk_cnt` value at the first mismatch; all-ones if there has been none.

## Operation
- States:
  - IDLE
  - FILL
  - CHECK
  - DONE
  - HALT
- IDLE → FILL when `en`=1.
- FILL:
  - Shift `d_in` into the expectation pipe each edge.
  - Go to CHECK once `LATENCY` entries are valid, which takes `LATENCY` edges.
- CHECK, at each edge:
  - `exp` = `d_in` captured `LATENCY` edges earlier.
  - `mis` = (`q_in` != `exp`).
  - `chk_cnt`++.
  - If `mis`: `err_cnt`++ (saturating). On the first mismatch only, `first_err` ← the pre-increment `chk_cnt`.
- CHECK → DONE when the incremented `chk_cnt` equals `NUM_CHECKS`.
- CHECK → HALT on `mis` when `STOP_ON_ERR`=1.
  - If the same edge also reaches `NUM_CHECKS`, HALT wins.
- DONE and HALT:
  - Counters frozen; `done`=1.
  - Exit only via `clr` or `rst_n`.
- `en`=0 in FILL or CHECK:
  - Return to IDLE and invalidate the pipe.
  - Counters are kept.
  - A later `en`=1 refills the pipe and resumes counting from the retained values.
- `en` is ignored in DONE and HALT.
- `clr`=1, from any state: go to IDLE, clear the pipe and counters, and set `first_err` to all-ones. `clr` overrides a simultaneous compare.

## Timing
- Reset values:
  - State IDLE, pipe invalid.
  - `done`=0, `pass`=0, `fail`=0.
  - `err_cnt`=0, `chk_cnt`=0.
  - `first_err`=all-ones.
- All outputs are registered.
- A compare at edge k is visible on the outputs after edge k. The first compare is at the `LATENCY`-th edge after the edge that sampled `en`=1.
- `q_in` is sampled at the same edge as `d_in`. A correct `dff` therefore shows `q_in` at edge k equal to `d_in` at edge k-1 (`LATENCY`=1).
- `pass` and `fail` follow from the registered counters and state, with no extra delay.
- Asserting `rst_n` mid-CHECK returns every output to its reset value immediately, with no clock needed.

## Structure
- Package `dff_chk_pkg` holds:
  - The state enum `chk_state_t` (IDLE, FILL, CHECK, DONE, HALT).
  - Constant `CHK_CNT_W_DEF`=16.
  - Function `sat_inc` (saturating increment).
- Sub-module `exp_pipe`:
  - `LATENCY`-deep shift register with a per-stage valid bit.
  - Ports: `clk`, `rst_n`, `flush`, `shift`, `din`, `dout`, `full`.
- `dff_checker` contains the FSM and counters.

## Test plan
- Good `dff`, toggle `d_in` every 7 time units with a 10-unit `clk`, `en`=1 → after 41 edges `done`=1, `pass`=1, `err_cnt`=0, `chk_cnt`=40, `first_err`=16'hFFFF.
- `q_in` tied to 0, `d_in`=1 constant → `err_cnt`=40, `first_err`=0, `fail`=1, `pass`=0.
- `STOP_ON_ERR`=1, force one wrong `q_in` at compare 5 → HALT, `chk_cnt`=6, `err_cnt`=1, `first_err`=5, `done`=1.
- Drop `en` after 10 compares for 3 edges, then re-raise → `chk_cnt` holds at 10, resumes after a `LATENCY`-edge refill, and `done` arrives at 40.
- `LATENCY`=3 with a 3-stage DUT → all pass. Same checker on a 1-stage DUT with a random `d_in` sequence → `err_cnt` > 0.
- Pull `rst_n` low mid-CHECK, then separately pulse `clr` in DONE → all outputs return to their reset values (`first_err`=all-ones) and state is IDLE.
